// File: rtl/fa_serial_seq.sv
// Bit-serial add/sub sequencer: a single 1-bit full adder processes one bit
// pair per clock, LSB first, and the result is returned over valid/ready.
module fa
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module fa_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] sh_next;

    fa u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign sh_next = {fa_s, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    cnt_d   = '0;
                    case (op)
                        2'b00:   begin b_d = b;  carry_d = 1'b0; end
                        2'b01:   begin b_d = ~b; carry_d = 1'b1; end
                        2'b10:   begin b_d = b;  carry_d = cin;  end
                        default: begin b_d = '0; carry_d = 1'b1; end
                    endcase
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = sh_next;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // On the MSB cycle the carry flop holds the carry into the MSB.
                    state_d  = DONE;
                    result_d = sh_next;
                    c_out_d  = fa_co;
                    ovf_d    = carry_q ^ fa_co;
                    zero_d   = (sh_next == '0);
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign res_valid   = (state_q == DONE);
    assign result      = result_q;
    assign c_out       = c_out_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
endmodule
